cachedir_sweep: RTL and testbench

//  Parametrised dual-port cache-directory RAM; next generation of the bridge's tag/state directory.

---
 rtl/cachedir_sweep.sv | 124 ++++++++++++
 tb/tb_cachedir_sweep.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cachedir_sweep.sv
// Dual-port tag/state directory RAM with registered reads, write-collision flag and a
// hardware invalidation sweep that runs after reset and on request.
module cachedir_sweep #(
  parameter int unsigned              ADDR_WIDTH  = 9,
  parameter int unsigned              DATA_WIDTH  = 29,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE  = '0,
  parameter bit                       WRITE_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  init_req,
  output logic                  ready,
  output logic                  collision,
  input  logic                  wren_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  wren_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned         Depth   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(Depth - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    collision_q, collision_d;
  logic [DATA_WIDTH-1:0]   q_a_q, q_a_d, q_b_q, q_b_d;

  logic [DATA_WIDTH-1:0]   mem [Depth];

  logic                    act, we_a, we_b, same_idx;
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;

  always_comb begin
    act      = (state_q == StReady) && enable;
    we_a     = act && wren_a;
    we_b     = act && wren_b;
    same_idx = (address_a == address_b);

    // Write-first forwarding; port B has priority when both ports hit the same index.
    rd_a = mem[address_a];
    rd_b = mem[address_b];
    if (WRITE_FIRST) begin
      if (we_b && same_idx) rd_a = data_b;
      else if (we_a)        rd_a = data_a;
      if (we_b)                  rd_b = data_b;
      else if (we_a && same_idx) rd_b = data_a;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    collision_d = 1'b0;
    q_a_d       = q_a_q;
    q_b_d       = q_b_q;
    unique case (state_q)
      StInit: begin
        q_a_d   = '0;
        q_b_d   = '0;
        ready_d = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StReady;
          ready_d = 1'b1;
        end
      end
      StReady: begin
        if (act) begin
          q_a_d       = rd_a;
          q_b_d       = rd_b;
          collision_d = we_a && we_b && same_idx;
        end
        if (init_req) begin
          state_d = StInit;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
      q_a_q       <= '0;
      q_b_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      collision_q <= collision_d;
      q_a_q       <= q_a_d;
      q_b_q       <= q_b_d;
    end
  end

  // Array has no reset; the sweep owns the write port while in StInit.
  always_ff @(posedge clock) begin
    if (state_q == StInit) begin
      mem[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    end else begin
      if (we_a) mem[address_a] <= data_a;
      if (we_b) mem[address_b] <= data_b;
    end
  end

  assign ready     = ready_q;
  assign collision = collision_q;
  assign q_a       = q_a_q;
  assign q_b       = q_b_q;

endmodule

// File: tb/tb_cachedir_sweep.sv
// Scoreboard bench for cachedir_sweep: one write-first instance and one read-first instance
// driven by the same directed stimulus.
module tb_cachedir_sweep;

  localparam int AW = 9;
  localparam int DW = 29;
  localparam logic [DW-1:0] InitV = 29'h1ABC;

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b1, init_req = 1'b0;
  logic wren_a = 1'b0, wren_b = 1'b0;
  logic [AW-1:0] address_a = '0, address_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;

  logic          rdy1, coll1, rdy2, coll2;
  logic [DW-1:0] q_a1, q_b1, q_a2, q_b2;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int          sel;
    int unsigned due;
    logic [DW-1:0] val;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cachedir_sweep #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(InitV), .WRITE_FIRST(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .init_req(init_req),
    .ready(rdy1), .collision(coll1),
    .wren_a(wren_a), .address_a(address_a), .data_a(data_a), .q_a(q_a1),
    .wren_b(wren_b), .address_b(address_b), .data_b(data_b), .q_b(q_b1)
  );

  cachedir_sweep #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE('0), .WRITE_FIRST(1'b0)) dut_rf (
    .clock(clock), .reset_n(reset_n), .enable(enable), .init_req(init_req),
    .ready(rdy2), .collision(coll2),
    .wren_a(wren_a), .address_a(address_a), .data_a(data_a), .q_a(q_a2),
    .wren_b(wren_b), .address_b(address_b), .data_b(data_b), .q_b(q_b2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // sel: 0 q_a(wf) 1 q_b(wf) 2 collision(wf) 3 ready(wf) 4 q_b(rf)
  function automatic logic [DW-1:0] actual(int sel);
    case (sel)
      0:       return q_a1;
      1:       return q_b1;
      2:       return {28'b0, coll1};
      3:       return {28'b0, rdy1};
      default: return q_b2;
    endcase
  endfunction

  task automatic push(int sel, logic [DW-1:0] v, string nm);
    exp_t e;
    e.sel = sel;
    e.due = cyc + 1;
    e.val = v;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    wren_a   = 1'b0;
    wren_b   = 1'b0;
    init_req = 1'b0;
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.nm, actual(mon_e.sel), mon_e.val);
    end
  end

  task automatic check_sweep_ready(int k);
    if (k == 511) begin
      chk("sweep_ready_low_511", {28'b0, rdy1}, 29'd0);
      chk("sweep_ready_low_511_rf", {28'b0, rdy2}, 29'd0);
    end
    if (k == 512) begin
      chk("sweep_ready_high_512", {28'b0, rdy1}, 29'd1);
      chk("sweep_ready_high_512_rf", {28'b0, rdy2}, 29'd1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", {28'b0, rdy1}, 29'd0);
    chk("rst_collision", {28'b0, coll1}, 29'd0);
    chk("rst_q_a", q_a1, 29'd0);
    chk("rst_q_b", q_b1, 29'd0);
    reset_n = 1'b1;

    // T1: power-up sweep and readback
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (k == 1) chk("sweep_ready_low_1", {28'b0, rdy1}, 29'd0);
      check_sweep_ready(k);
    end
    address_a = 9'd0;
    address_b = 9'd255;
    push(0, InitV, "t1_idx0");
    push(1, InitV, "t1_idx255");
    push(4, 29'd0, "t1_idx255_rf");
    tick();
    address_a = 9'd511;
    push(0, InitV, "t1_idx511");

    // T2: write on A, read on B, hold when disabled
    tick();
    wren_a = 1'b1; address_a = 9'd5; data_a = 29'h0123456;
    tick();
    address_b = 9'd5;
    push(1, 29'h0123456, "t2_read");
    push(4, 29'h0123456, "t2_read_rf");
    tick();
    enable = 1'b0; address_b = 9'd0;
    push(1, 29'h0123456, "t2_hold");
    push(4, 29'h0123456, "t2_hold_rf");
    tick();
    enable = 1'b1;

    // T3: same-index collision, then different indices
    tick();
    wren_a = 1'b1; address_a = 9'd7; data_a = 29'h1;
    wren_b = 1'b1; address_b = 9'd7; data_b = 29'h2;
    push(0, 29'h2, "t3_wf_q_a");
    push(1, 29'h2, "t3_wf_q_b");
    push(2, 29'd1, "t3_collision");
    push(4, 29'd0, "t3_rf_old");
    tick();
    push(0, 29'h2, "t3_stored_a");
    push(1, 29'h2, "t3_stored_b");
    push(2, 29'd0, "t3_collision_pulse");
    push(4, 29'h2, "t3_stored_rf");
    tick();
    wren_a = 1'b1; address_a = 9'd10; data_a = 29'h11;
    wren_b = 1'b1; address_b = 9'd11; data_b = 29'h22;
    push(0, 29'h11, "t3_own_wf_a");
    push(1, 29'h22, "t3_own_wf_b");
    push(2, 29'd0, "t3_no_collision");
    push(4, 29'd0, "t3_rf_old_11");
    tick();
    address_a = 9'd11; address_b = 9'd10;
    push(0, 29'h22, "t3_read_11");
    push(1, 29'h11, "t3_read_10");
    push(4, 29'h11, "t3_read_10_rf");

    // T4: read-first versus write-first on a cross-port write
    tick();
    wren_a = 1'b1; address_a = 9'd9; data_a = 29'h3; address_b = 9'd0;
    tick();
    wren_a = 1'b1; address_a = 9'd9; data_a = 29'h4; address_b = 9'd9;
    push(1, 29'h4, "t4_wf_new");
    push(4, 29'h3, "t4_rf_old");
    tick();
    push(1, 29'h4, "t4_wf_after");
    push(4, 29'h4, "t4_rf_after");
    tick();
    wren_a = 1'b1; address_a = 9'd12; data_a = 29'h33; address_b = 9'd12;
    push(1, 29'h33, "t4_wf_cross");
    push(4, 29'd0, "t4_rf_cross");

    // T5: fill everything, request a sweep, attempt writes during it
    for (int i = 0; i < 256; i++) begin
      tick();
      wren_a = 1'b1; address_a = AW'(2 * i);     data_a = DW'(32'h100 + 2 * i);
      wren_b = 1'b1; address_b = AW'(2 * i + 1); data_b = DW'(32'h100 + 2 * i + 1);
    end
    tick();
    init_req = 1'b1;
    wren_a = 1'b1; address_a = 9'd3; data_a = 29'h55; address_b = 9'd3;
    push(1, 29'h55, "t5_initreq_read");
    push(4, 29'h103, "t5_initreq_read_rf");
    push(3, 29'd0, "t5_ready_drop");
    for (int k = 0; k <= 512; k++) begin
      tick();
      if (k == 1) chk("t5_q_forced", q_b1, 29'd0);
      check_sweep_ready(k);
      if (k < 512) begin
        wren_a = 1'b1; address_a = AW'(k); data_a = 29'h7777;
      end
    end
    for (int i = 0; i < 256; i++) begin
      address_a = AW'(2 * i);
      address_b = AW'(2 * i + 1);
      push(0, InitV, "t5_swept_a");
      push(1, InitV, "t5_swept_b");
      push(4, 29'd0, "t5_swept_rf");
      tick();
    end

    // T6: reset mid-sweep, then a full sweep again
    init_req = 1'b1;
    for (int k = 0; k <= 200; k++) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ready", {28'b0, rdy1}, 29'd0);
    chk("t6_rst_q_a", q_a1, 29'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      tick();
      check_sweep_ready(k);
    end
    address_a = 9'd0;
    push(0, InitV, "t6_read_after");
    tick();

    // Async reset while outputs are non-zero
    wren_a = 1'b1; address_a = 9'd30; data_a = 29'h5;
    wren_b = 1'b1; address_b = 9'd30; data_b = 29'h6;
    tick();
    #1;
    chk("pre_rst_collision", {28'b0, coll1}, 29'd1);
    chk("pre_rst_q_a", q_a1, 29'h6);
    reset_n = 1'b0;
    #1;
    chk("async_rst_collision", {28'b0, coll1}, 29'd0);
    chk("async_rst_q_a", q_a1, 29'd0);
    chk("async_rst_q_b", q_b1, 29'd0);
    chk("async_rst_ready", {28'b0, rdy1}, 29'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("queue_drained", DW'(exp_q.size()), 29'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
